register_file_32x32: RTL and testbench

//   32-entry x 32-bit general-purpose register file for the single-cycle CPU datapath.
//   Two independent combinational read ports (A, B) and one synchronous write port.

---
 rtl/register_file_32x32.sv | 44 ++++
 tb/tb_register_file_32x32.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_32x32.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port.
// Register 0 is hardwired to zero; reset is asynchronous and active-low.
module register_file_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] R_Addr_A,
    input  logic [ADDR_WIDTH-1:0] R_Addr_B,
    input  logic [ADDR_WIDTH-1:0] W_Addr,
    input  logic [DATA_WIDTH-1:0] W_Data,
    input  logic                  Write_Reg,
    output logic [DATA_WIDTH-1:0] R_Data_A,
    output logic [DATA_WIDTH-1:0] R_Data_B
);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // Next-state array: a write to address 0 is dropped so reg0 never leaves zero.
    always_comb begin
        regs_d = regs_q;
        if (Write_Reg && (W_Addr != '0)) begin
            regs_d[W_Addr] = W_Data;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Address 0 is forced to zero at the mux so it reads 0 even before the first reset.
    assign R_Data_A = (R_Addr_A == '0) ? '0 : regs_q[R_Addr_A];
    assign R_Data_B = (R_Addr_B == '0) ? '0 : regs_q[R_Addr_B];

endmodule

// File: tb/tb_register_file_32x32.sv
// Self-checking bench for register_file_32x32: directed scenarios plus randomized
// traffic compared against a plain array model of the register file.
module tb_register_file_32x32;

    logic        Clk;
    logic        Reset;
    logic [4:0]  R_Addr_A;
    logic [4:0]  R_Addr_B;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_Reg;
    logic [31:0] R_Data_A;
    logic [31:0] R_Data_B;

    logic [31:0] model [32];
    int passCount;
    int checkCount;

    register_file_32x32 dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .R_Addr_A  (R_Addr_A),
        .R_Addr_B  (R_Addr_B),
        .W_Addr    (W_Addr),
        .W_Data    (W_Data),
        .Write_Reg (Write_Reg),
        .R_Data_A  (R_Data_A),
        .R_Data_B  (R_Data_B)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one cycle of stimulus at the falling edge, then apply the write rule to the model at the rising edge.
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] ra, input logic [4:0] rb);
        @(negedge Clk);
        Write_Reg = we;
        W_Addr    = wa;
        W_Data    = wd;
        R_Addr_A  = ra;
        R_Addr_B  = rb;
        @(posedge Clk);
        if (Reset === 1'b1 && we && wa != 5'd0) model[wa] = wd;
        #1;
    endtask

    task automatic test_reset;
        #3;
        Reset    = 1'b0;
        R_Addr_A = 5'd0;
        R_Addr_B = 5'd31;
        #1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        checkCount++;
        if (R_Data_A !== 32'h0) $display("[TB] FAIL reset_a0: got %h expected %h", R_Data_A, 32'h0);
        else passCount++;
        checkCount++;
        if (R_Data_B !== 32'h0) $display("[TB] FAIL reset_b31: got %h expected %h", R_Data_B, 32'h0);
        else passCount++;
        for (int i = 0; i < 32; i++) begin
            R_Addr_A = 5'(i);
            R_Addr_B = 5'(31 - i);
            #1;
            checkCount++;
            if (R_Data_A !== 32'h0 || R_Data_B !== 32'h0)
                $display("[TB] FAIL reset_all addr %0d: got A=%h B=%h expected 0", i, R_Data_A, R_Data_B);
            else passCount++;
        end
        applyStimulus(1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd7);
        checkCount++;
        if (R_Data_A !== 32'h0) $display("[TB] FAIL write_in_reset: got %h expected %h", R_Data_A, 32'h0);
        else passCount++;
        @(negedge Clk);
        Write_Reg = 1'b0;
        Reset     = 1'b1;
    endtask

    task automatic test_write_read;
        applyStimulus(1'b1, 5'd1, 32'hFFFF_AAAA, 5'd1, 5'd0);
        checkCount++;
        if (R_Data_A !== model[1]) $display("[TB] FAIL write_read: got %h expected %h", R_Data_A, model[1]);
        else passCount++;
    endtask

    task automatic test_second_write;
        applyStimulus(1'b1, 5'd30, 32'hAAAA_FFFF, 5'd1, 5'd30);
        applyStimulus(1'b0, 5'd30, 32'h1111_2222, 5'd1, 5'd30);
        checkCount++;
        if (R_Data_A !== 32'hFFFF_AAAA || R_Data_B !== 32'hAAAA_FFFF)
            $display("[TB] FAIL second_write: got A=%h B=%h expected A=%h B=%h",
                     R_Data_A, R_Data_B, 32'hFFFF_AAAA, 32'hAAAA_FFFF);
        else passCount++;
        applyStimulus(1'b0, 5'd1, 32'h3333_4444, 5'd1, 5'd30);
        checkCount++;
        if (R_Data_A !== model[1] || R_Data_B !== model[30])
            $display("[TB] FAIL hold_no_write: got A=%h B=%h expected A=%h B=%h",
                     R_Data_A, R_Data_B, model[1], model[30]);
        else passCount++;
    endtask

    task automatic test_read_during_write;
        @(negedge Clk);
        R_Addr_A  = 5'd5;
        R_Addr_B  = 5'd5;
        W_Addr    = 5'd5;
        W_Data    = 32'h1234_5678;
        Write_Reg = 1'b1;
        #1;
        checkCount++;
        if (R_Data_A !== 32'h0) $display("[TB] FAIL rdw_before: got %h expected %h", R_Data_A, 32'h0);
        else passCount++;
        @(posedge Clk);
        model[5] = 32'h1234_5678;
        #1;
        checkCount++;
        if (R_Data_A !== 32'h1234_5678 || R_Data_B !== 32'h1234_5678)
            $display("[TB] FAIL rdw_after: got A=%h B=%h expected %h", R_Data_A, R_Data_B, 32'h1234_5678);
        else passCount++;
    endtask

    task automatic test_reg0;
        applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
        checkCount++;
        if (R_Data_A !== 32'h0 || R_Data_B !== 32'h0)
            $display("[TB] FAIL reg0_write: got A=%h B=%h expected 0", R_Data_A, R_Data_B);
        else passCount++;
    endtask

    task automatic test_async_reset;
        applyStimulus(1'b0, 5'd1, 32'h0, 5'd1, 5'd30);
        checkCount++;
        if (R_Data_A !== 32'hFFFF_AAAA) $display("[TB] FAIL pre_async: got %h expected %h", R_Data_A, 32'hFFFF_AAAA);
        else passCount++;
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        checkCount++;
        if (R_Data_A !== 32'h0 || R_Data_B !== 32'h0)
            $display("[TB] FAIL async_reset: got A=%h B=%h expected 0", R_Data_A, R_Data_B);
        else passCount++;
        applyStimulus(1'b1, 5'd1, 32'h5555_6666, 5'd1, 5'd1);
        @(negedge Clk);
        Write_Reg = 1'b0;
        Reset     = 1'b1;
        #1;
        checkCount++;
        if (R_Data_A !== 32'h0) $display("[TB] FAIL write_ignored_in_reset: got %h expected %h", R_Data_A, 32'h0);
        else passCount++;
    endtask

    // Consecutive writes to one register on consecutive edges; each must land exactly one edge later.
    task automatic test_back_to_back;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            applyStimulus(1'b1, 5'd12, d, 5'd12, 5'd12);
            checkCount++;
            if (R_Data_A !== d || R_Data_B !== d)
                $display("[TB] FAIL back_to_back %0d: got A=%h B=%h expected %h", i, R_Data_A, R_Data_B, d);
            else passCount++;
        end
    endtask

    task automatic test_random;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] expA;
        logic [31:0] expB;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            ra = (i % 4 == 0) ? wa : 5'($urandom_range(0, 31));
            rb = (i % 7 == 0) ? ra : 5'($urandom_range(0, 31));
            @(negedge Clk);
            Write_Reg = we;
            W_Addr    = wa;
            W_Data    = wd;
            R_Addr_A  = ra;
            R_Addr_B  = rb;
            #1;
            expA = model[ra];
            expB = model[rb];
            checkCount++;
            if (R_Data_A !== expA || R_Data_B !== expB)
                $display("[TB] FAIL random_pre %0d: got A=%h B=%h expected A=%h B=%h",
                         i, R_Data_A, R_Data_B, expA, expB);
            else passCount++;
            @(posedge Clk);
            if (we && wa != 5'd0) model[wa] = wd;
            #1;
            expA = model[ra];
            expB = model[rb];
            checkCount++;
            if (R_Data_A !== expA || R_Data_B !== expB)
                $display("[TB] FAIL random_post %0d: got A=%h B=%h expected A=%h B=%h",
                         i, R_Data_A, R_Data_B, expA, expB);
            else passCount++;
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        Reset      = 1'b1;
        Write_Reg  = 1'b0;
        W_Addr     = 5'd0;
        W_Data     = 32'h0;
        R_Addr_A   = 5'd0;
        R_Addr_B   = 5'd0;
        test_reset();
        test_write_read();
        test_second_write();
        test_read_during_write();
        test_reg0();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
